// File: rtl/gate_truth_table_sequencer.sv
// Logic-gate exercise controller: debounced keys step operands a,b through all
// four rows of a selectable gate and accumulate its truth-table column on the LEDs.
module gate_truth_table_sequencer #(
  parameter int unsigned STEP_CYCLES     = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key,
  output logic [9:0] led,
  output logic       auto_mode
);

  localparam int unsigned TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {MANUAL, AUTO, HOLD} state_t;

  logic [3:0]    sync1, sync2, deb, press;
  logic [DW-1:0] cnt [4];

  state_t        state, state_n;
  logic [1:0]    row, row_n;
  logic [2:0]    op, op_n;
  logic [3:0]    tbl, tbl_n;
  logic [TW-1:0] timer, timer_n;
  logic          hold, hold_n;
  logic          tc, step, fcur;

  function automatic logic gate_f(input logic [2:0] o, input logic a, input logic b);
    case (o)
      3'd0:    gate_f = a & b;
      3'd1:    gate_f = a | b;
      3'd2:    gate_f = ~a;
      3'd3:    gate_f = a ^ b;
      3'd4:    gate_f = ~(a & b);
      3'd5:    gate_f = ~(a | b);
      3'd6:    gate_f = ~(a ^ b);
      default: gate_f = a & ~b;
    endcase
  endfunction

  // Counter only runs while the synchronised level disagrees with the accepted one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      press <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i]   <= '0;
          deb[i]   <= sync2[i];
          press[i] <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign tc   = (timer == TW'(STEP_CYCLES - 1));
  assign fcur = gate_f(op, row[1], row[0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MANUAL;
      row   <= '0;
      op    <= '0;
      tbl   <= '0;
      timer <= '0;
      hold  <= 1'b0;
    end else begin
      state <= state_n;
      row   <= row_n;
      op    <= op_n;
      tbl   <= tbl_n;
      timer <= timer_n;
      hold  <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    op_n    = op;
    tbl_n   = tbl;
    timer_n = timer;
    hold_n  = hold;
    step    = 1'b0;
    if (state != MANUAL) timer_n = tc ? '0 : timer + 1'b1;

    if (press[3]) begin
      row_n   = '0;
      tbl_n   = '0;
      timer_n = '0;
      hold_n  = 1'b0;
      state_n = MANUAL;
    end else if (press[1]) begin
      timer_n = '0;
      hold_n  = 1'b0;
      state_n = (state == MANUAL) ? AUTO : MANUAL;
    end else if (press[2]) begin
      op_n    = op + 1'b1;
      row_n   = '0;
      tbl_n   = '0;
      timer_n = '0;
      hold_n  = 1'b0;
      if (state == HOLD) state_n = AUTO;
    end else begin
      case (state)
        MANUAL: step = press[0];
        AUTO: if (tc) begin
          step = 1'b1;
          if (row == 2'd3) state_n = HOLD;
        end
        HOLD: if (tc) begin
          // second terminal count in HOLD advances to the next gate
          if (hold) begin
            op_n    = op + 1'b1;
            row_n   = '0;
            tbl_n   = '0;
            hold_n  = 1'b0;
            state_n = AUTO;
          end else begin
            hold_n = 1'b1;
          end
        end
        default: state_n = MANUAL;
      endcase
    end

    if (step) begin
      if (row == 2'd0) tbl_n = '0;
      tbl_n[row] = fcur;
      row_n      = row + 1'b1;
    end
  end

  assign led       = {tbl, op, fcur, row[0], row[1]};
  assign auto_mode = (state != MANUAL);

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Randomised scoreboard bench for gate_truth_table_sequencer: a truth-table model
// predicts every change of {auto_mode, led}; a monitor pops and compares each change.
module tb_gate_truth_table_sequencer;

  localparam int unsigned STEP = 8;
  localparam int unsigned DEB  = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] key = '1;
  logic [9:0] led;
  logic       auto_mode;

  gate_truth_table_sequencer #(.STEP_CYCLES(STEP), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key(key),
    .led(led),
    .auto_mode(auto_mode)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [10:0] q[$];
  int          chg_t[$];
  bit          mon_en = 1'b0;
  logic [10:0] prev;
  logic [10:0] mon_exp;

  // truth-table column per gate, bit index = {a,b}
  logic [3:0]  tt [8];
  int          m_row, m_op;
  logic [3:0]  m_tbl;
  bit          m_auto;
  logic [10:0] last_exp;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev = {auto_mode, led};
    end else if ({auto_mode, led} !== prev) begin
      prev = {auto_mode, led};
      chg_t.push_back(cyc);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change got=%b expected=no change", prev);
      end else begin
        mon_exp = q.pop_front();
        if (prev !== mon_exp) begin
          errors++;
          $display("FAIL out_seq got=%b expected=%b", prev, mon_exp);
        end
      end
    end
  end

  function automatic logic [10:0] model_out();
    int a = m_row / 2;
    int b = m_row % 2;
    logic [3:0] col = tt[m_op];
    return {m_auto, m_tbl, 3'(m_op), col[m_row], 1'(b), 1'(a)};
  endfunction

  task automatic m_push();
    logic [10:0] e = model_out();
    if (e !== last_exp) begin
      q.push_back(e);
      last_exp = e;
    end
  endtask

  task automatic m_step();
    logic [3:0] col = tt[m_op];
    if (m_row == 0) m_tbl = '0;
    m_tbl[m_row] = col[m_row];
    m_row = (m_row + 1) % 4;
    m_push();
  endtask

  task automatic m_clear(input int next_op);
    m_op  = next_op % 8;
    m_row = 0;
    m_tbl = '0;
    m_push();
  endtask

  task automatic m_reset();
    m_row = 0; m_op = 0; m_tbl = '0; m_auto = 1'b0; last_exp = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    logic [10:0] e = model_out();
    chk(name, {21'd0, auto_mode, led}, {21'd0, e});
  endtask

  task automatic press(input logic [3:0] mask);
    @(negedge clk);
    key = ~mask;
    repeat (DEB + 6) @(negedge clk);
    key = '1;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout got=%0d pending expected=0", q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [3:0] mask;
    tt = '{4'b1000, 4'b1110, 4'b0011, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0100};
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset_led", {22'd0, led}, 32'd0);
    chk("reset_auto", {31'd0, auto_mode}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    #1 mon_en = 1'b1;

    // idle: nothing may change
    repeat (100) @(negedge clk);
    chk("idle_led", {22'd0, led}, 32'd0);
    chk("idle_auto", {31'd0, auto_mode}, 32'd0);

    // manual stepping through AND
    for (int i = 0; i < 5; i++) begin
      m_step();
      press(4'b0001);
      chk_model("manual_step");
      if (i == 2) chk("and_row3_f", {31'd0, led[2]}, 32'd1);
      if (i == 3) chk("and_full", {22'd0, led}, {22'd0, 10'b1000_000_000});
    end

    // bouncing key0 then held: single step
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      key[0] = ~key[0];
      repeat (2) @(negedge clk);
    end
    m_step();
    key[0] = 1'b0;
    repeat (10) @(negedge clk);
    key = '1;
    repeat (DEB + 6) @(negedge clk);
    chk_model("bounce_one_step");
    chk("bounce_row", {30'd0, led[0], led[1]}, 32'd2);

    // next op eight times
    for (int i = 0; i < 8; i++) begin
      m_clear(m_op + 1);
      press(4'b0100);
      chk("next_op", {29'd0, led[5:3]}, 32'((i + 1) % 8));
      chk_model("next_op_clear");
    end

    // auto run, hold, gate advance, then back to manual
    m_clear(m_op);
    press(4'b1000);
    chg_t.delete();
    m_auto = 1'b1;
    m_push();
    for (int i = 0; i < 4; i++) m_step();
    m_clear(m_op + 1);
    press(4'b0010);
    drain();
    m_step();
    m_auto = 1'b0;
    m_push();
    repeat (3) @(negedge clk);
    press(4'b0010);
    drain();
    chk("auto_events", chg_t.size(), 8);
    if (chg_t.size() >= 6) begin
      for (int i = 1; i < 5; i++) chk("auto_step_period", chg_t[i] - chg_t[i-1], STEP);
      chk("hold_period", chg_t[5] - chg_t[4], 2 * STEP);
    end
    chk_model("auto_exit");

    // restart beats a same-cycle step
    m_step();
    press(4'b0001);
    m_clear(m_op);
    press(4'b1001);
    chk_model("restart_priority");
    chk("restart_row_tbl", {26'd0, led[9:6], led[1:0]}, 32'd0);

    // random manual traffic
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: begin mask = 4'b0001; m_step(); end
        1: begin mask = 4'b0100; m_clear(m_op + 1); end
        default: begin mask = 4'b1000; m_clear(m_op); end
      endcase
      press(mask);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      chk_model("random_press");
    end

    // reset while in HOLD
    m_clear(m_op);
    press(4'b1000);
    m_auto = 1'b1;
    m_push();
    for (int i = 0; i < 4; i++) m_step();
    press(4'b0010);
    drain();
    repeat (5) @(negedge clk);
    chk("in_hold_auto", {31'd0, auto_mode}, 32'd1);
    #3;
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_reset_led", {22'd0, led}, 32'd0);
    chk("async_reset_auto", {31'd0, auto_mode}, 32'd0);
    m_reset();
    q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1 mon_en = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_led", {22'd0, led}, 32'd0);
    chk("post_reset_auto", {31'd0, auto_mode}, 32'd0);

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
